// File: rtl/vector_pkg.sv
// Shared encodings and lane helpers for the vector load/store sequencer.
package vector_pkg;

  localparam logic [2:0] W8  = 3'b000;
  localparam logic [2:0] W16 = 3'b101;
  localparam logic [2:0] W32 = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2,
    S_ADV   = 2'd3
  } lsu_state_e;

  function automatic logic [2:0] ebytes(input logic [2:0] width);
    case (width)
      W8:      ebytes = 3'd1;
      W16:     ebytes = 3'd2;
      W32:     ebytes = 3'd4;
      default: ebytes = 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] width);
    case (width)
      W8:      lane_mask = 4'b0001;
      W16:     lane_mask = 4'b0011;
      W32:     lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Legal width with the base naturally aligned to the element size.
  function automatic logic base_ok(input logic [2:0] width, input logic [1:0] lo);
    case (width)
      W8:      base_ok = 1'b1;
      W16:     base_ok = (lo[0] == 1'b0);
      W32:     base_ok = (lo == 2'b00);
      default: base_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vector_lsu_ctrl_if.sv
// Scalar data-bus request/acknowledge bundle driven by the vector LSU sequencer.
interface vector_lsu_ctrl_if;
  logic [31:0] o_dbus_adr;
  logic        o_dbus_cyc;
  logic        o_dbus_we;
  logic [3:0]  o_dbus_sel;
  logic        i_dbus_ack;

  modport master (output o_dbus_adr, output o_dbus_cyc, output o_dbus_we,
                  output o_dbus_sel, input i_dbus_ack);
  modport slave  (input o_dbus_adr, input o_dbus_cyc, input o_dbus_we,
                  input o_dbus_sel, output i_dbus_ack);
endinterface

// File: rtl/vector_lsu_ctrl.sv
// Unit-stride vector load/store sequencer: one element per bus transaction,
// driving the external byte-lane aligner and VRF port.
module vector_lsu_ctrl
  import vector_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int VL_W = 5,
  parameter int WI_W = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_is_store,
  input  logic [2:0]           i_width,
  input  logic [31:0]          i_base,
  input  logic [VL_W-1:0]      i_vl,
  input  logic [4:0]           i_vreg,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  vector_lsu_ctrl_if.master    dbus,
  output logic [1:0]           o_shift_offset,
  output logic [1:0]           o_vreg_shift,
  output logic [2:0]           o_width,
  output logic [5+WI_W-1:0]    o_vrf_addr,
  output logic                 o_vrf_we,
  output logic [3:0]           o_vrf_be
);

  lsu_state_e        r_state, w_nxt_state;
  logic [VL_W-1:0]   r_idx, w_nxt_idx, r_vl, w_nxt_vl;
  logic [31:0]       r_addr, w_nxt_addr;
  logic [2:0]        r_width, w_nxt_width;
  logic [4:0]        r_vreg, w_nxt_vreg;
  logic              r_is_store, w_nxt_store;
  logic              w_nxt_done, w_nxt_err;

  logic [1:0]        w_slot, w_lane_ofs;
  logic [VL_W-1:0]   w_widx_full;
  logic [WI_W-1:0]   w_widx;
  logic [3:0]        w_sel, w_be;

  logic              r_busy, r_done, r_err, r_cyc, r_we, r_vrf_we;
  logic [31:0]       r_adr;
  logic [3:0]        r_sel, r_vrf_be;
  logic [1:0]        r_shift_offset, r_vreg_shift;
  logic [5+WI_W-1:0] r_vrf_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_vl       <= '0;
      r_addr     <= 32'd0;
      r_width    <= 3'b000;
      r_vreg     <= 5'd0;
      r_is_store <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_idx      <= w_nxt_idx;
      r_vl       <= w_nxt_vl;
      r_addr     <= w_nxt_addr;
      r_width    <= w_nxt_width;
      r_vreg     <= w_nxt_vreg;
      r_is_store <= w_nxt_store;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_vl    = r_vl;
    w_nxt_addr  = r_addr;
    w_nxt_width = r_width;
    w_nxt_vreg  = r_vreg;
    w_nxt_store = r_is_store;
    w_nxt_done  = 1'b0;
    w_nxt_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nxt_idx   = '0;
          w_nxt_vl    = i_vl;
          w_nxt_addr  = i_base;
          w_nxt_width = i_width;
          w_nxt_vreg  = i_vreg;
          w_nxt_store = i_is_store;
          if (!base_ok(i_width, i_base[1:0])) begin
            w_nxt_err = 1'b1;
          end else if (i_vl == '0) begin
            w_nxt_done = 1'b1;
          end else begin
            w_nxt_state = S_ISSUE;
          end
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (dbus.i_dbus_ack) begin
          w_nxt_state = r_is_store ? S_ADV : S_WB;
        end else begin
          w_nxt_state = S_ISSUE;
        end
      end
      S_WB: w_nxt_state = S_ADV;
      S_ADV: begin
        w_nxt_idx  = r_idx + VL_W'(1);
        w_nxt_addr = r_addr + {29'd0, ebytes(r_width)};
        if (w_nxt_idx == r_vl) begin
          w_nxt_state = S_IDLE;
          w_nxt_done  = 1'b1;
        end else begin
          w_nxt_state = S_ISSUE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Register slot, VRF lane offset and word index follow the elements-per-word ratio.
  always_comb begin
    w_slot      = 2'd0;
    w_lane_ofs  = 2'd0;
    w_widx_full = w_nxt_idx;
    case (w_nxt_width)
      W8: begin
        w_slot      = w_nxt_idx[1:0];
        w_lane_ofs  = w_nxt_idx[1:0];
        w_widx_full = w_nxt_idx >> 2'd2;
      end
      W16: begin
        w_slot      = {1'b0, w_nxt_idx[0]};
        w_lane_ofs  = {w_nxt_idx[0], 1'b0};
        w_widx_full = w_nxt_idx >> 2'd1;
      end
      default: begin
        w_slot      = 2'd0;
        w_lane_ofs  = 2'd0;
        w_widx_full = w_nxt_idx;
      end
    endcase
    w_widx = WI_W'(w_widx_full % (VLEN / 32));
    w_sel  = lane_mask(w_nxt_width) << w_nxt_addr[1:0];
    w_be   = lane_mask(w_nxt_width) << w_lane_ofs;
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_cyc          <= 1'b0;
      r_we           <= 1'b0;
      r_sel          <= 4'b0000;
      r_adr          <= 32'd0;
      r_shift_offset <= 2'd0;
      r_vreg_shift   <= 2'd0;
      r_vrf_addr     <= '0;
      r_vrf_we       <= 1'b0;
      r_vrf_be       <= 4'b0000;
    end else begin
      r_busy         <= (w_nxt_state != S_IDLE);
      r_done         <= w_nxt_done;
      r_err          <= w_nxt_err;
      r_cyc          <= (w_nxt_state == S_ISSUE);
      r_we           <= (w_nxt_state == S_ISSUE) && w_nxt_store;
      r_sel          <= (w_nxt_state == S_ISSUE) ? w_sel : 4'b0000;
      r_adr          <= {w_nxt_addr[31:2], 2'b00};
      r_shift_offset <= w_nxt_addr[1:0];
      r_vreg_shift   <= w_slot;
      r_vrf_addr     <= {w_nxt_vreg, w_widx};
      r_vrf_we       <= (w_nxt_state == S_WB);
      r_vrf_be       <= (w_nxt_state == S_WB) ? w_be : 4'b0000;
    end
  end

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign dbus.o_dbus_cyc = r_cyc;
  assign dbus.o_dbus_we  = r_we;
  assign dbus.o_dbus_sel = r_sel;
  assign dbus.o_dbus_adr = r_adr;
  assign o_shift_offset  = r_shift_offset;
  assign o_vreg_shift    = r_vreg_shift;
  assign o_width         = r_width;
  assign o_vrf_addr      = r_vrf_addr;
  assign o_vrf_we        = r_vrf_we;
  assign o_vrf_be        = r_vrf_be;

endmodule

// File: doc/vector_lsu_ctrl.md
Name: vector_lsu_ctrl

Overview:
- Sequencer for unit-stride vector loads and stores, one element at a time, over the scalar data bus.
- Per element it:
  - generates the word-aligned bus address and byte selects;
  - drives the byte-lane aligner's offset, slot and width fields;
  - on loads, writes the aligned word into the vector register file with byte enables.
- Sits between the vector decode stage and the data bus / aligner / VRF.

Parameters:
- VLEN, 128, vector register length in bits (multiple of 32).
- VL_W, 5, width of element-count input; must hold VLEN/8.
- WI_W, 2, word-index width inside one vreg, equals log2(VLEN/32).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_is_store  in  1  1 = store, 0 = load.
- i_width  in  3  element width: 000 = 8b, 101 = 16b, 110 = 32b.
- i_base  in  32  base byte address.
- i_vl  in  VL_W  element count.
- i_vreg  in  5  vector register index (vd for loads, vs3 for stores).
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  one-cycle error pulse; replaces o_done on error.
- o_dbus_adr  out  32  word address, bits[1:0] = 0.
- o_dbus_cyc  out  1  bus request.
- o_dbus_we  out  1  write strobe.
- o_dbus_sel  out  4  byte selects.
- i_dbus_ack  in  1  bus acknowledge.
- o_shift_offset  out  2  aligner memory-side offset = element address[1:0].
- o_vreg_shift  out  2  aligner register-side slot = element index mod (4/ebytes).
- o_width  out  3  aligner width, registered copy of i_width.
- o_vrf_addr  out  5+WI_W  {vreg, word index}; used for VRF read on stores and VRF write on loads.
- o_vrf_we  out  1  VRF write strobe (loads only).
- o_vrf_be  out  4  VRF byte enables.

Behaviour:
- Reset: all outputs 0; state IDLE; element counter 0.
- Reset mid-operation: o_dbus_cyc and o_busy are low in the cycle after reset is sampled, and no o_done is produced.
- ebytes = 1/2/4 for width 000/101/110.
- Per element i:
  - addr = base + i*ebytes;
  - slot = i mod (4/ebytes);
  - word index = i / (4/ebytes).
- IDLE:
  - i_start = 1 latches width, base, vl, vreg, is_store; o_busy rises next cycle.
  - Illegal width, or base not aligned to ebytes → next cycle o_err = 1, no bus cycle, return to IDLE.
  - vl = 0 → next cycle o_done = 1, no bus cycle.
  - Otherwise go to ISSUE.
- ISSUE:
  - o_dbus_cyc = 1.
  - o_dbus_adr = {addr[31:2], 2'b00}.
  - o_dbus_sel = mask << addr[1:0], where mask = 0001 / 0011 / 1111.
  - o_dbus_we = is_store.
  - Aligner fields and o_vrf_addr are valid and held stable for the whole state.
  - Stay in ISSUE until i_dbus_ack = 1.
  - On ack: o_dbus_cyc drops next cycle; load → WB; store → ADV.
- WB (loads only, 1 cycle):
  - o_vrf_we = 1.
  - o_vrf_be = mask << (slot*ebytes).
  - o_vrf_addr held from ISSUE.
  - Aligner fields held, so the aligner output is the write data.
  - Go to ADV.
- ADV (1 cycle):
  - i = i+1.
  - If i == vl → o_done = 1, return to IDLE; else → ISSUE.
- Minimum per-element latency: load 3 cycles (ack in first ISSUE cycle), store 2 cycles.
- i_dbus_ack outside ISSUE is ignored.
- i_start while busy is ignored.
- Address arithmetic is 32-bit modulo (wraps past 0xFFFFFFFC).

Decomposition:
- Shared package vector_pkg:
  - width encodings W8 = 000, W16 = 101, W32 = 110;
  - state encoding IDLE/ISSUE/WB/ADV;
  - function ebytes(width) and function lane_mask(width).
- No sub-module: address/slot generation is inline counters; the aligner stays outside, driven by this block.

Test Plan:
- Byte load, base=0x1002, vl=3 → bus words 0x1000 ×2 then 0x1004; sel 0100, 1000, 0001; shift_offset 2, 3, 0; vreg_shift 0, 1, 2; vrf_be 0001, 0010, 0100; one o_done.
- Halfword store, base=0x2000, vl=4, ack delayed 2 cycles each → 4 bus writes; sel 0011, 1100, 0011, 1100; o_vrf_we never asserted; o_vrf_addr word index 0, 0, 1, 1; cyc held until ack.
- vl=0 → o_done the cycle after start, o_dbus_cyc never high; i_width=011 → o_err pulse, no o_done.
- Word load, base=0x3002 (misaligned) → o_err, no bus activity; then base=0x3000, vl=2 → addresses 0x3000, 0x3004; sel 1111; vreg_shift 0.
- Reset asserted while in ISSUE with cyc high → next cycle cyc=0, busy=0, no done; subsequent i_start executes normally from element 0.
- i_start pulsed during busy, and stray ack in IDLE → both ignored; counters and outputs unchanged.
